// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers the
// returned words in a small prefetch FIFO and drives the registered decode-stage slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        incr_pc_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] d_inst_o,
  output logic [31:0] d_pc_o,
  output logic        d_valid_o
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam int          SW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]   d_inst_q, d_inst_d, d_pc_q, d_pc_d;
  logic          d_valid_q, d_valid_d;

  logic [31:0] fifo_inst_mem [FIFO_DEPTH];
  logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0] pcq_mem       [FIFO_DEPTH];

  logic [SW-1:0] inflight;
  logic          accept, push, pop, fifo_nonempty;

  // Credit covers both buffered words and responses still owed, so the FIFO never overflows.
  assign inflight      = SW'(outstanding_q) + SW'(fifo_cnt_q);
  assign imem_req_o    = rst_n_i && !redirect_i && (inflight < SW'(FIFO_DEPTH));
  assign imem_addr_o   = fetch_pc_q;
  assign accept        = imem_req_o && imem_gnt_i;
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign push          = imem_rvalid_i && (discard_q == '0) && !redirect_i;
  assign pop           = !redirect_i && !stall_i && incr_pc_i && fifo_nonempty;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid_i);
    discard_d     = discard_q;
    fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
    fifo_wr_d     = fifo_wr_q + PW'(push);
    fifo_rd_d     = fifo_rd_q + PW'(pop);
    pcq_wr_d      = pcq_wr_q + PW'(accept);
    pcq_rd_d      = pcq_rd_q + PW'(imem_rvalid_i);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      // Every response still owed after this cycle belongs to the abandoned path.
      discard_d  = outstanding_q - CW'(imem_rvalid_i);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    d_inst_d  = d_inst_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (redirect_i) begin
      d_inst_d  = NOP;
      d_valid_d = 1'b0;
    end else if (!stall_i && incr_pc_i) begin
      if (fifo_nonempty) begin
        d_inst_d  = fifo_inst_mem[fifo_rd_q];
        d_pc_d    = fifo_pc_mem[fifo_rd_q];
        d_valid_d = 1'b1;
      end else begin
        d_inst_d  = NOP;
        d_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_cnt_q    <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      d_inst_q      <= NOP;
      d_pc_q        <= '0;
      d_valid_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      d_inst_q      <= d_inst_d;
      d_pc_q        <= d_pc_d;
      d_valid_q     <= d_valid_d;
    end
  end

  // Storage needs no reset: pointers and counts alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_inst_mem[fifo_wr_q] <= imem_rdata_i;
      fifo_pc_mem[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
    end
    if (accept) pcq_mem[pcq_wr_q] <= fetch_pc_q;
  end

  assign d_inst_o  = d_inst_q;
  assign d_pc_o    = d_pc_q;
  assign d_valid_o = d_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory responder with one-cycle latency
// (optionally held off) and hand-computed expectations checked at each falling edge.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        incr_pc_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] d_inst_o;
  logic [31:0] d_pc_o;
  logic        d_valid_o;

  logic        rsp_hold;
  logic [31:0] pend[$];
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .incr_pc_i     (incr_pc_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .d_inst_o      (d_inst_o),
    .d_pc_o        (d_pc_o),
    .d_valid_o     (d_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: grants seen in a cycle are answered in the next cycle unless held.
  always begin
    @(negedge clk_i);
    if (!rst_n_i) pend.delete();
    else if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
    @(posedge clk_i);
    #1;
    if (!rst_n_i) begin
      pend.delete();
      imem_rvalid_i = 1'b0;
    end else if (pend.size() > 0 && !rsp_hold) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(d_valid_o), 32'd1);
    chk({tag, "_pc"}, d_pc_o, pc);
    chk({tag, "_inst"}, d_inst_o, inst_of(pc));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(d_valid_o), 32'd0);
    chk({tag, "_inst"}, d_inst_o, NOP);
  endtask

  // Leaves the bench at the start of cycle 0 after reset release, inputs idle.
  task automatic do_reset();
    next_cycle();
    rst_n_i = 1'b0;
    imem_gnt_i = 1'b0; incr_pc_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; rsp_hold = 1'b0;
    next_cycle();
    next_cycle();
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    incr_pc_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; rsp_hold = 1'b0;

    // Reset values
    repeat (2) next_cycle();
    sample();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h100);
    chk("rst_inst", d_inst_o, NOP);
    chk("rst_pc", d_pc_o, 32'h0);
    chk("rst_valid", 32'(d_valid_o), 32'd0);
    $display("reset: req=%0b addr=%h d_inst=%h", imem_req_o, imem_addr_o, d_inst_o);

    // Streaming from RESET_PC: credit of 2 gives a valid,valid,bubble rhythm
    next_cycle(); rst_n_i = 1'b1; imem_gnt_i = 1'b1; incr_pc_i = 1'b1;
    sample(); chk("s_c0_req", 32'(imem_req_o), 32'd1); chk("s_c0_addr", imem_addr_o, 32'h100);
    chk_bubble("s_c0");
    next_cycle(); sample(); chk("s_c1_addr", imem_addr_o, 32'h104);
    chk("s_c1_req", 32'(imem_req_o), 32'd1);
    next_cycle(); sample(); chk("s_c2_req", 32'(imem_req_o), 32'd0); chk_bubble("s_c2");
    next_cycle(); sample(); chk_d("s_c3", 32'h100);
    $display("stream: first valid d_pc=%h on cycle 3", d_pc_o);
    next_cycle(); sample(); chk_d("s_c4", 32'h104);
    next_cycle(); sample(); chk_bubble("s_c5");
    next_cycle(); sample(); chk_d("s_c6", 32'h108);

    // Stall for 3 cycles: D frozen, FIFO fills, request drops
    next_cycle(); stall_i = 1'b1; sample(); chk_d("st_c7", 32'h10C);
    next_cycle(); sample(); chk_d("st_c8", 32'h10C); chk("st_c8_req", 32'(imem_req_o), 32'd0);
    next_cycle(); sample(); chk_d("st_c9", 32'h10C); chk("st_c9_req", 32'(imem_req_o), 32'd0);
    next_cycle(); stall_i = 1'b0; sample(); chk_d("st_c10", 32'h10C);
    next_cycle(); sample(); chk_d("st_c11", 32'h110);
    next_cycle(); sample(); chk_d("st_c12", 32'h114);
    $display("stall: resumed at d_pc=%h", d_pc_o);

    // Redirect with two responses outstanding
    do_reset(); imem_gnt_i = 1'b1; incr_pc_i = 1'b1; rsp_hold = 1'b1;
    sample();
    next_cycle(); sample(); chk("r_c1_addr", imem_addr_o, 32'h104);
    next_cycle(); redirect_i = 1'b1; redirect_pc_i = 32'h200;
    sample(); chk("r_c2_req", 32'(imem_req_o), 32'd0);
    rsp_hold = 1'b0;
    next_cycle(); redirect_i = 1'b0;
    sample(); chk("r_c3_addr", imem_addr_o, 32'h200); chk("r_c3_req", 32'(imem_req_o), 32'd0);
    chk_bubble("r_c3");
    next_cycle(); sample(); chk("r_c4_req", 32'(imem_req_o), 32'd1); chk_bubble("r_c4");
    next_cycle(); sample(); chk("r_c5_addr", imem_addr_o, 32'h204); chk_bubble("r_c5");
    next_cycle(); sample(); chk_bubble("r_c6");
    next_cycle(); sample(); chk_d("r_c7", 32'h200);
    $display("redirect: stale dropped, d_pc=%h", d_pc_o);

    // Grant withheld for 5 cycles
    do_reset(); imem_gnt_i = 1'b0; incr_pc_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      sample();
      chk($sformatf("g_c%0d_req", i), 32'(imem_req_o), 32'd1);
      chk($sformatf("g_c%0d_addr", i), imem_addr_o, 32'h100);
      chk_bubble($sformatf("g_c%0d", i));
    end
    next_cycle(); imem_gnt_i = 1'b1;
    sample();
    repeat (3) next_cycle();
    sample(); chk_d("g_c8", 32'h100);
    $display("no-grant: first valid d_pc=%h", d_pc_o);

    // Redirect and stall together while D holds a valid instruction
    do_reset(); imem_gnt_i = 1'b1; incr_pc_i = 1'b1;
    repeat (3) next_cycle();
    sample(); chk_d("rs_c3", 32'h100);
    next_cycle(); redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h203;
    sample(); chk("rs_c4_req", 32'(imem_req_o), 32'd0); chk_d("rs_c4", 32'h104);
    next_cycle(); redirect_i = 1'b0; stall_i = 1'b0;
    sample(); chk_bubble("rs_c5"); chk("rs_c5_pc", d_pc_o, 32'h104);
    chk("rs_c5_addr", imem_addr_o, 32'h200); chk("rs_c5_req", 32'(imem_req_o), 32'd1);
    repeat (3) next_cycle();
    sample(); chk_d("rs_c8", 32'h200);
    $display("redirect+stall: d_pc=%h", d_pc_o);

    // Asynchronous reset with two requests outstanding
    do_reset(); imem_gnt_i = 1'b1; incr_pc_i = 1'b1;
    repeat (3) next_cycle();
    sample(); rsp_hold = 1'b1;
    next_cycle(); stall_i = 1'b1;
    next_cycle();
    sample(); chk("ar_c5_req", 32'(imem_req_o), 32'd0); chk_d("ar_c5", 32'h104);
    #2; rst_n_i = 1'b0; #1;
    chk("ar_req", 32'(imem_req_o), 32'd0);
    chk("ar_addr", imem_addr_o, 32'h100);
    chk("ar_inst", d_inst_o, NOP);
    chk("ar_pc", d_pc_o, 32'h0);
    chk("ar_valid", 32'(d_valid_o), 32'd0);
    next_cycle(); stall_i = 1'b0; rsp_hold = 1'b0;
    next_cycle(); rst_n_i = 1'b1;
    sample(); chk("ar_c0_addr", imem_addr_o, 32'h100); chk("ar_c0_req", 32'(imem_req_o), 32'd1);
    chk_bubble("ar_c0");
    next_cycle(); sample(); chk_bubble("ar_c1");
    next_cycle(); sample(); chk_bubble("ar_c2");
    next_cycle(); sample(); chk_d("ar_c3", 32'h100);
    $display("async reset: restart d_pc=%h", d_pc_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
